mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter and sequencer for the single shared word-addressed memory in the multicycle MIPS core. It owns the memory port and serves two requesters over a req/ack handshake: the CPU datapath (instruction fetch and data access, already muxed by `iord`) and a DMA/loader port. Accesses are serialized with fair round-robin and a fixed memory read latency. The main controller holds its FETCH, MEMRD and MEMWR states until `cpu_ack`.

## Interface
- `AW`, 32, address width (byte address, passed through unchanged)
- `DW`, 32, data width
- `MEM_LAT`, 1, cycles from `mem_en` to valid `mem_rdata`; legal range 1..8
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `cpu_req`, `cpu_we`  in  1  CPU request / write enable
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_rdata`  out  DW  CPU read data register
- `cpu_ack`  out  1  CPU completion pulse
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ack`: same directions, widths and meaning as the CPU port
- `mem_en`, `mem_we`  out  1  memory strobe / write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data
- `busy`  out  1  high in any state other than IDLE
- `owner`  out  1  current or last grant: 0 = CPU, 1 = DMA

## Operation
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if any request is present, pick a winner, latch its we/addr/wdata into command registers, set `owner`, go to ISSUE. Otherwise stay.
- **Arbitration:** with one request, grant it. With both, grant the requester that is not `owner`, i.e. strict alternation. Reset value of `owner` is 1, so the CPU wins the first tie.
- **ISSUE:** `mem_en`=1 for exactly this cycle. `mem_we`, `mem_addr` and `mem_wdata` come from the command registers. Counter loads `MEM_LAT-1`. Go to WAIT.
- **WAIT:** decrement the counter. When counter==0, load `mem_rdata` into the owner's rdata register (read only; writes leave rdata unchanged) and go to RESP.
- **RESP:** the owner's ack=1 for exactly one cycle, then go to IDLE.
- **Requester contract:** hold req, we, addr and wdata stable from assertion until the ack cycle.
  - req high in the cycle after ack counts as a new request.
  - req dropped before ack is a protocol violation; the arbiter still completes the latched access.
- Loser's req stays pending. Maximum wait is one full foreign transaction.
- Command registers decouple memory outputs from live requester inputs.
- Non-owner rdata holds its previous value. Ack is never asserted to the non-owner.

## Timing
- Request sampled in IDLE at cycle T:
  - ISSUE at T+1
  - WAIT from T+2 through T+1+MEM_LAT
  - rdata captured at the end of T+1+MEM_LAT
  - ack at T+2+MEM_LAT
  - IDLE at T+3+MEM_LAT
- MEM_LAT=1 gives ack at T+3. Throughput is one access per MEM_LAT+3 cycles.
- All outputs are registered or decoded from registered state. There is no combinational path from req to mem_*.
- **Reset values after the reset edge:** state=IDLE, `mem_en`=`mem_we`=0, `mem_addr`=`mem_wdata`=0, both rdata=0, both ack=0, `busy`=0, `owner`=1, counter=0.
- **Reset mid-transaction:** the access is abandoned and no ack is issued. A write whose ISSUE cycle coincides with the reset cycle may still reach memory. Requesters must re-request.
- Requests present in the same cycle reset deasserts are sampled in the following IDLE cycle.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_t` (IDLE, ISSUE, WAIT, RESP)
  - `owner_t` (OWN_CPU=0, OWN_DMA=1)
  - `MEM_LAT_MAX`=8
- Sub-module `rr_arb2`: combinational two-way round-robin picker. Inputs are the two reqs and `owner`. Outputs are a grant-valid bit and the winner.
- Counter width is `$clog2(MEM_LAT_MAX)`.

## Test plan
- **CPU read, MEM_LAT=1:** `cpu_addr`=0x40, memory word 0x8C020004, req at T → `mem_en` only at T+1, `cpu_rdata`=0x8C020004 with `cpu_ack` at T+3, `dma_ack` stays 0.
- **DMA write then CPU read of the same address:** `dma_we`=1, addr 0x100, data 0xDEADBEEF → `mem_we`=1 in ISSUE, `dma_ack` one cycle. Then CPU read of 0x100 returns 0xDEADBEEF and `dma_rdata` is unchanged.
- **Simultaneous requests from reset, both held for 4 transactions:** grants go CPU, DMA, CPU, DMA. `owner` toggles each time and each ack is exactly one cycle.
- **MEM_LAT=4:** read at T → ack at T+6. `mem_rdata` driven with a wrong value before T+5 must not be captured.
- **Reset asserted during WAIT of a DMA read:** no `dma_ack`, IDLE with `owner`=1 after the edge. The next simultaneous request is granted to the CPU.
- **Back-to-back CPU:** req held continuously with a new addr in the cycle after ack → the next ISSUE occurs MEM_LAT+3 cycles after the previous ISSUE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and limits for the memory arbiter (state enum, owner enum, MEM_LAT_MAX)
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;
  localparam int MEM_LAT_MAX = 8;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker; in cpu_req/dma_req/owner, out valid (any req) and win (on a tie the requester that is not owner)
import mem_arb_pkg::*;
module rr_arb2 (
  input  logic   cpu_req,
  input  logic   dma_req,
  input  owner_t owner,
  output logic   valid,
  output owner_t win
);
  assign valid = cpu_req | dma_req;
  assign win = (cpu_req & dma_req) ? owner_t'(~owner) : (dma_req ? OWN_DMA : OWN_CPU);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes CPU and DMA req/ack ports onto one memory port (mem_en/we/addr/wdata out, mem_rdata in after MEM_LAT), with busy/owner status
import mem_arb_pkg::*;
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);
  localparam int CW = $clog2(MEM_LAT_MAX);
  arb_state_t state, state_nx;
  owner_t own, win;
  logic grant;
  logic cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [CW-1:0] cnt;
  rr_arb2 u_arb (
    .cpu_req(cpu_req),
    .dma_req(dma_req),
    .owner(own),
    .valid(grant),
    .win(win)
  );
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (grant ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (cnt == '0 ? RESP : WAIT) : IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      own       <= OWN_DMA;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cnt       <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      if (state == IDLE && grant) begin
        own       <= win;
        cmd_we    <= win == OWN_DMA ? dma_we : cpu_we;
        cmd_addr  <= win == OWN_DMA ? dma_addr : cpu_addr;
        cmd_wdata <= win == OWN_DMA ? dma_wdata : cpu_wdata;
      end
      if (state == ISSUE) cnt <= CW'(MEM_LAT - 1);
      if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (state == WAIT && cnt == '0 && !cmd_we) begin
        if (own == OWN_DMA) dma_rdata <= mem_rdata;
        else cpu_rdata <= mem_rdata;
      end
    end
  end
  always_comb begin
    mem_en    = state == ISSUE;
    mem_we    = state == ISSUE && cmd_we;
    mem_addr  = cmd_addr;
    mem_wdata = cmd_wdata;
    cpu_ack   = state == RESP && own == OWN_CPU;
    dma_ack   = state == RESP && own == OWN_DMA;
    busy      = state != IDLE;
    owner     = own;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter at MEM_LAT=1 and MEM_LAT=4
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0, cpu_req4 = 0, dma_req4 = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_ack, dma_ack, mem_en, mem_we, busy, owner;
  logic [31:0] cpu_rdata4, dma_rdata4, mem_addr4, mem_wdata4;
  logic [31:0] mem_rdata4 = 0;
  logic cpu_ack4, dma_ack4, mem_en4, mem_we4, busy4, owner4;
  logic [31:0] mem [0:255];
  int n_checks = 0;
  int n_errors = 0;
  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );
  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(4)) dut4 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req4), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata4), .cpu_ack(cpu_ack4),
    .dma_req(dma_req4), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata4), .dma_ack(dma_ack4),
    .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata4), .busy(busy4), .owner(owner4)
  );
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[9:2]];
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[16] = 32'h8C020004;
    tick;
    tick;
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 1);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    check("rst_acks", {cpu_ack, dma_ack}, 0);
    reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    tick;
    check("rd_issue_en", mem_en, 1);
    check("rd_issue_addr", mem_addr, 32'h40);
    check("rd_owner", owner, 0);
    tick;
    check("rd_wait_en", mem_en, 0);
    check("rd_wait_ack", cpu_ack, 0);
    tick;
    check("rd_ack", cpu_ack, 1);
    check("rd_data", cpu_rdata, 32'h8C020004);
    check("rd_dma_ack", dma_ack, 0);
    cpu_req = 0;
    tick;
    check("rd_ack_pulse", cpu_ack, 0);
    check("rd_idle", busy, 0);
    dma_req = 1; dma_we = 1; dma_addr = 32'h100; dma_wdata = 32'hDEADBEEF;
    tick;
    check("wr_issue_en", mem_en, 1);
    check("wr_issue_we", mem_we, 1);
    check("wr_issue_addr", mem_addr, 32'h100);
    check("wr_issue_data", mem_wdata, 32'hDEADBEEF);
    check("wr_owner", owner, 1);
    tick;
    check("wr_wait_we", mem_we, 0);
    tick;
    check("wr_ack", dma_ack, 1);
    check("wr_cpu_ack", cpu_ack, 0);
    check("wr_dma_rdata", dma_rdata, 0);
    dma_req = 0; dma_we = 0;
    tick;
    check("wr_ack_pulse", dma_ack, 0);
    cpu_req = 1; cpu_addr = 32'h100;
    tick;
    tick;
    tick;
    check("rb_ack", cpu_ack, 1);
    check("rb_data", cpu_rdata, 32'hDEADBEEF);
    check("rb_dma_rdata", dma_rdata, 0);
    cpu_req = 0;
    tick;
    reset = 1;
    tick;
    reset = 0;
    cpu_req = 1; cpu_addr = 32'h40; dma_req = 1; dma_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("rr_owner", owner, i % 2);
      check("rr_addr", mem_addr, (i % 2) ? 32'h100 : 32'h40);
      tick;
      tick;
      check("rr_cpu_ack", cpu_ack, (i % 2) == 0);
      check("rr_dma_ack", dma_ack, (i % 2) == 1);
      tick;
      check("rr_ack_drop", {cpu_ack, dma_ack}, 0);
    end
    check("rr_dma_rdata", dma_rdata, 32'hDEADBEEF);
    check("rr_cpu_rdata", cpu_rdata, 32'h8C020004);
    cpu_req = 0; dma_req = 0;
    tick;
    dma_req = 1; dma_addr = 32'h100;
    tick;
    check("rw_issue_owner", owner, 1);
    tick;
    reset = 1;
    tick;
    check("rw_dma_ack", dma_ack, 0);
    check("rw_busy", busy, 0);
    check("rw_owner", owner, 1);
    reset = 0;
    cpu_req = 1; cpu_addr = 32'h40;
    tick;
    check("rw_grant_cpu", owner, 0);
    check("rw_issue_addr", mem_addr, 32'h40);
    tick;
    tick;
    check("rw_cpu_ack", cpu_ack, 1);
    check("rw_no_dma_ack", dma_ack, 0);
    cpu_req = 0; dma_req = 0;
    tick;
    tick;
    cpu_req = 1; cpu_addr = 32'h40;
    tick;
    check("b2b_issue0", mem_en, 1);
    tick;
    check("b2b_wait", mem_en, 0);
    tick;
    check("b2b_ack", cpu_ack, 1);
    cpu_addr = 32'h100;
    tick;
    check("b2b_idle", mem_en, 0);
    tick;
    check("b2b_issue1", mem_en, 1);
    check("b2b_addr1", mem_addr, 32'h100);
    tick;
    tick;
    check("b2b_data1", cpu_rdata, 32'hDEADBEEF);
    cpu_req = 0;
    tick;
    cpu_addr = 32'h40; mem_rdata4 = 32'h0BAD0BAD; cpu_req4 = 1;
    tick;
    check("l4_issue", mem_en4, 1);
    tick;
    check("l4_wait", mem_en4, 0);
    tick;
    tick;
    check("l4_no_early_ack", cpu_ack4, 0);
    tick;
    check("l4_no_ack_t5", cpu_ack4, 0);
    check("l4_busy", busy4, 1);
    mem_rdata4 = 32'h12345678;
    tick;
    check("l4_ack", cpu_ack4, 1);
    check("l4_data", cpu_rdata4, 32'h12345678);
    cpu_req4 = 0; mem_rdata4 = 32'h0BAD0BAD;
    tick;
    check("l4_ack_pulse", cpu_ack4, 0);
    check("l4_hold", cpu_rdata4, 32'h12345678);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
